// File: rtl/sliced_wide_adder_pkg.sv
// Shared types and constants for the slice-serial wide adder.
// Holds the FSM encoding, default geometry and the slice-index width helper.
package sliced_wide_adder_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_SLICE = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Width of a counter that walks nslice slices; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned nslice);
    if (nslice <= 1) begin
      return 1;
    end
    return $clog2(nslice);
  endfunction

endpackage

// File: rtl/sliced_wide_adder_lookahead.sv
// One SLICE-bit add using a propagate/generate carry chain.
// Purely combinational; exposes every internal carry for the parent.
module slice_lookahead_sum #(
  parameter int unsigned SLICE = 8
) (
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  input  logic             cin_i,
  output logic [SLICE-1:0] sum_o,
  output logic [SLICE-1:0] carry_o
);

  logic [SLICE-1:0] p;
  logic [SLICE-1:0] g;
  logic             c_prev;

  assign p = a_i ^ b_i;
  assign g = a_i & b_i;

  // c[k] = G[k] | P[k] & c[k-1], with the slice carry-in seeding the chain.
  always_comb begin
    sum_o   = '0;
    carry_o = '0;
    c_prev  = cin_i;
    for (int k = 0; k < int'(SLICE); k++) begin
      sum_o[k]   = p[k] ^ c_prev;
      carry_o[k] = g[k] | (p[k] & c_prev);
      c_prev     = carry_o[k];
    end
  end

endmodule

// File: rtl/sliced_wide_adder.sv
// Multi-cycle WIDTH-bit adder that processes one SLICE-bit slice per clock,
// rippling the carry between slices through a register, behind valid/ready.
module sliced_wide_adder
  import sliced_wide_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned IDXW   = idx_width(NSLICE);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  state_e state_q, state_d;

  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic             out_cout_q, out_cout_d;
  logic             out_ovf_q, out_ovf_d;

  logic [SLICE-1:0] slice_a;
  logic [SLICE-1:0] slice_b;
  logic [SLICE-1:0] slice_sum;
  logic [SLICE-1:0] slice_c;
  logic             msb_cin;
  logic             last_slice;
  logic             unused_carries;

  assign last_slice = (idx_q == LAST_IDX);

  // Select the operand slice addressed by the running index.
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int s = 0; s < int'(NSLICE); s++) begin
      if (idx_q == IDXW'(s)) begin
        slice_a = a_q[s*SLICE +: SLICE];
        slice_b = b_q[s*SLICE +: SLICE];
      end
    end
  end

  slice_lookahead_sum #(
    .SLICE (SLICE)
  ) u_slice (
    .a_i     (slice_a),
    .b_i     (slice_b),
    .cin_i   (carry_q),
    .sum_o   (slice_sum),
    .carry_o (slice_c)
  );

  // Carry into the MSB: inside the slice, or the registered carry when SLICE=1.
  generate
    if (SLICE > 1) begin : g_multi_bit
      assign msb_cin = slice_c[SLICE-2];
    end else begin : g_single_bit
      assign msb_cin = carry_q;
    end
  endgenerate

  assign unused_carries = ^slice_c;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)   state_d = ST_RUN;
      ST_RUN:  if (last_slice) state_d = ST_DONE;
      ST_DONE: if (out_ready)  state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register only.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: in_ready  = 1'b1;
      ST_DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath next-state: operand capture, slice accumulation, result load.
  always_comb begin
    idx_d      = idx_q;
    carry_d    = carry_q;
    a_d        = a_q;
    b_d        = b_q;
    sum_d      = sum_q;
    out_sum_d  = out_sum_q;
    out_cout_d = out_cout_q;
    out_ovf_d  = out_ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_cin;
          idx_d   = '0;
        end
      end
      ST_RUN: begin
        for (int s = 0; s < int'(NSLICE); s++) begin
          if (idx_q == IDXW'(s)) begin
            sum_d[s*SLICE +: SLICE] = slice_sum;
          end
        end
        carry_d = slice_c[SLICE-1];
        if (last_slice) begin
          out_sum_d  = sum_d;
          out_cout_d = slice_c[SLICE-1];
          out_ovf_d  = slice_c[SLICE-1] ^ msb_cin;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q      <= '0;
      carry_q    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      out_sum_q  <= '0;
      out_cout_q <= 1'b0;
      out_ovf_q  <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      carry_q    <= carry_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sum_q      <= sum_d;
      out_sum_q  <= out_sum_d;
      out_cout_q <= out_cout_d;
      out_ovf_q  <= out_ovf_d;
    end
  end

  assign out_sum  = out_sum_q;
  assign out_cout = out_cout_q;
  assign out_ovf  = out_ovf_q;

endmodule
